// File: rtl/sevenseg_score_scanner.sv
// Sequential double-dabble score converter driving a scanned common-anode seven-segment display.
// Optional leading-zero blanking is enabled by defining SEVENSEG_LZ_BLANK_EN.
module sevenseg_score_scanner #(
    parameter int NUM_DIGITS = 4,
    parameter int BIN_W      = 10,
    parameter int SCAN_DIV   = 250000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [BIN_W-1:0]          value,
    input  logic                      load,
    output logic                      busy,
    output logic                      ovf,
    output logic [4*NUM_DIGITS-1:0]   bcd,
    output logic [NUM_DIGITS-1:0]     an,
    output logic [6:0]                seg
);

    localparam int ACC_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

    localparam logic [63:0] MAX_VAL = pow10(NUM_DIGITS) - 64'd1;

    function automatic logic [ACC_W-1:0] dabble_adj(input logic [ACC_W-1:0] a);
        logic [ACC_W-1:0] r;
        r = a;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (a[4*i +: 4] >= 4'd5) r[4*i +: 4] = a[4*i +: 4] + 4'd3;
        return r;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = 7'b1111111;
        endcase
    endfunction

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t             state, state_nxt;
    logic [BIN_W-1:0]   shreg, cap, pend_val;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   cnt;
    logic               pend;
    logic               restart;

    assign restart = pend || load;
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load) state_nxt = SHIFT;
            SHIFT:   if (cnt == CNT_W'(1)) state_nxt = COMMIT;
            COMMIT:  state_nxt = restart ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A load arriving during COMMIT restarts directly with the live value, which is the newest request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg    <= '0;
            cap      <= '0;
            pend_val <= '0;
            acc      <= '0;
            cnt      <= '0;
            pend     <= 1'b0;
            bcd      <= '0;
            ovf      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (load) begin
                    shreg <= value;
                    cap   <= value;
                    acc   <= '0;
                    cnt   <= CNT_W'(BIN_W);
                end
                SHIFT: begin
                    {acc, shreg} <= {dabble_adj(acc), shreg} << 1;
                    cnt          <= cnt - CNT_W'(1);
                    if (load) begin
                        pend_val <= value;
                        pend     <= 1'b1;
                    end
                end
                COMMIT: begin
                    if (64'(cap) > MAX_VAL) begin
                        bcd <= {NUM_DIGITS{4'h9}};
                        ovf <= 1'b1;
                    end else begin
                        bcd <= acc;
                        ovf <= 1'b0;
                    end
                    if (restart) begin
                        shreg <= load ? value : pend_val;
                        cap   <= load ? value : pend_val;
                        acc   <= '0;
                        cnt   <= CNT_W'(BIN_W);
                    end
                    pend <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    logic [DIV_W-1:0] div;
    logic [IDX_W-1:0] idx;
    logic             blank;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div <= '0;
            idx <= '0;
        end else if (div == DIV_W'(SCAN_DIV - 1)) begin
            div <= '0;
            idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
        end else begin
            div <= div + DIV_W'(1);
        end
    end

`ifdef SEVENSEG_LZ_BLANK_EN
    logic [IDX_W-1:0] top_nz;

    always_comb begin
        top_nz = '0;
        for (int i = 1; i < NUM_DIGITS; i++)
            if (bcd[4*i +: 4] != 4'd0) top_nz = IDX_W'(i);
        blank = !ovf && (idx > top_nz);
    end
`else
    assign blank = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= '1;
            seg <= 7'b1111111;
        end else begin
            an  <= blank ? '1 : ~(NUM_DIGITS'(1) << idx);
            seg <= blank ? 7'b1111111 : seg_decode(bcd[idx*4 +: 4]);
        end
    end

endmodule

// File: tb/tb_sevenseg_score_scanner.sv
// Randomized self-checking bench: a 4-digit and a 3-digit instance checked against an arithmetic digit model.
module tb_sevenseg_score_scanner;

    localparam int BW = 10;
    localparam int SD = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [BW-1:0]   value4, value3;
    logic            load4, load3;
    logic            busy4, ovf4, busy3, ovf3;
    logic [15:0]     bcd4;
    logic [11:0]     bcd3;
    logic [3:0]      an4;
    logic [2:0]      an3;
    logic [6:0]      seg4, seg3;

    int checks = 0;
    int errors = 0;
    int cyc;
    logic [6:0] seg_tab [10];

    sevenseg_score_scanner #(.NUM_DIGITS(4), .BIN_W(BW), .SCAN_DIV(SD)) dut (
        .clk(clk), .rst(rst), .value(value4), .load(load4), .busy(busy4),
        .ovf(ovf4), .bcd(bcd4), .an(an4), .seg(seg4)
    );

    sevenseg_score_scanner #(.NUM_DIGITS(3), .BIN_W(BW), .SCAN_DIV(SD)) dut3 (
        .clk(clk), .rst(rst), .value(value3), .load(load3), .busy(busy3),
        .ovf(ovf3), .bcd(bcd3), .an(an3), .seg(seg3)
    );

    always #5 clk = ~clk;

    // clock edges seen since reset was last released
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    function automatic int pow10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [31:0] ref_bcd(input int v, input int n);
        logic [31:0] r = '0;
        int p = 1;
        for (int i = 0; i < n; i++) begin
            r[4*i +: 4] = (v > pow10(n) - 1) ? 4'd9 : 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    task automatic conv4(input int v, output int hi);
        @(negedge clk); value4 = BW'(v); load4 = 1'b1;
        @(negedge clk); load4 = 1'b0; hi = 0;
        while (busy4 && hi < 100) begin hi++; @(negedge clk); end
    endtask

    task automatic conv3(input int v, output int hi);
        @(negedge clk); value3 = BW'(v); load3 = 1'b1;
        @(negedge clk); load3 = 1'b0; hi = 0;
        while (busy3 && hi < 100) begin hi++; @(negedge clk); end
    endtask

    task automatic test_reset();
        int hi;
        conv4(321, hi);
        @(negedge clk); #2 rst = 1'b1; #1;
        checks++;
        if (busy4 !== 1'b0 || ovf4 !== 1'b0 || bcd4 !== 16'h0 || an4 !== 4'hf || seg4 !== 7'h7f) begin
            errors++;
            $display("FAIL reset_async: busy=%b ovf=%b bcd=%h an=%b seg=%b expected 0 0 0000 1111 1111111",
                     busy4, ovf4, bcd4, an4, seg4);
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_convert();
        int hi, v;
        logic [31:0] e;
        for (int it = 0; it < 10; it++) begin
            v = (it == 0) ? 123 : (it == 1) ? 0 : (it == 2) ? 1023 : int'($urandom_range(0, 1023));
            conv4(v, hi);
            e = ref_bcd(v, 4);
            checks++;
            if (hi !== BW + 1) begin
                errors++;
                $display("FAIL busy_len v=%0d: got %0d cycles expected %0d", v, hi, BW + 1);
            end
            checks++;
            if (bcd4 !== e[15:0] || ovf4 !== 1'b0) begin
                errors++;
                $display("FAIL convert v=%0d: bcd=%h ovf=%b expected %h 0", v, bcd4, ovf4, e[15:0]);
            end
        end
    endtask

    task automatic test_overflow();
        int hi, v;
        logic [31:0] e;
        for (int it = 0; it < 10; it++) begin
            v = (it == 0) ? 1023 : (it == 1) ? 999 : (it == 2) ? 1000 : int'($urandom_range(0, 1023));
            conv3(v, hi);
            e = ref_bcd(v, 3);
            checks++;
            if (bcd3 !== e[11:0] || ovf3 !== (v > 999)) begin
                errors++;
                $display("FAIL overflow v=%0d: bcd=%h ovf=%b expected %h %b", v, bcd3, ovf3, e[11:0], v > 999);
            end
        end
    endtask

    task automatic test_scan(input int v);
        int hi, idx;
        logic blank;
        logic [31:0] e;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        conv4(v, hi);
        e = ref_bcd(v, 4);
        repeat (16) begin
            @(negedge clk);
            idx = ((cyc - 1) / SD) % 4;
            blank = 1'b0;
`ifdef SEVENSEG_LZ_BLANK_EN
            begin
                int top = 0;
                for (int i = 1; i < 4; i++) if (e[4*i +: 4] != 4'd0) top = i;
                blank = (idx > top);
            end
`endif
            exp_an  = blank ? 4'hf : ~(4'b0001 << idx);
            exp_seg = blank ? 7'h7f : seg_tab[e[4*idx +: 4]];
            checks++;
            if (an4 !== exp_an || seg4 !== exp_seg) begin
                errors++;
                $display("FAIL scan v=%0d idx=%0d: an=%b seg=%b expected %b %b", v, idx, an4, seg4, exp_an, exp_seg);
            end
        end
    endtask

    task automatic test_back_to_back();
        int a, b, c;
        logic [31:0] ea, ec;
        for (int it = 0; it < 3; it++) begin
            if (it == 0) begin a = 5; b = 42; c = 77; end
            else begin
                a = int'($urandom_range(0, 1023));
                b = int'($urandom_range(0, 1023));
                c = int'($urandom_range(0, 1023));
            end
            ea = ref_bcd(a, 4);
            ec = ref_bcd(c, 4);
            @(negedge clk); value4 = BW'(a); load4 = 1'b1;
            @(negedge clk); value4 = BW'(b);
            @(negedge clk); value4 = BW'(c);
            @(negedge clk); load4 = 1'b0;
            repeat (9) @(negedge clk);
            checks++;
            if (bcd4 !== ea[15:0] || busy4 !== 1'b1) begin
                errors++;
                $display("FAIL b2b_first a=%0d: bcd=%h busy=%b expected %h 1", a, bcd4, busy4, ea[15:0]);
            end
            repeat (11) @(negedge clk);
            checks++;
            if (bcd4 !== ec[15:0] || busy4 !== 1'b0) begin
                errors++;
                $display("FAIL b2b_second c=%0d: bcd=%h busy=%b expected %h 0", c, bcd4, busy4, ec[15:0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic saw;
        @(negedge clk); value4 = BW'(500); load4 = 1'b1;
        @(negedge clk); load4 = 1'b0;
        @(negedge clk); value4 = BW'(99); load4 = 1'b1;
        @(negedge clk); load4 = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1; #1;
        checks++;
        if (busy4 !== 1'b0 || ovf4 !== 1'b0 || bcd4 !== 16'h0 || an4 !== 4'hf || seg4 !== 7'h7f) begin
            errors++;
            $display("FAIL reset_mid: busy=%b ovf=%b bcd=%h an=%b seg=%b expected 0 0 0000 1111 1111111",
                     busy4, ovf4, bcd4, an4, seg4);
        end
        @(negedge clk); rst = 1'b0;
        saw = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (busy4 !== 1'b0 || bcd4 !== 16'h0) saw = 1'b1;
        end
        checks++;
        if (saw) begin
            errors++;
            $display("FAIL reset_no_commit: activity after reset, busy=%b bcd=%h expected 0 0000", busy4, bcd4);
        end
    endtask

    initial begin
        seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
        seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
        seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
        seg_tab[9] = 7'b0010000;
        value4 = '0; value3 = '0; load4 = 1'b0; load3 = 1'b0;
        #12 rst = 1'b0;
        test_reset();
        test_convert();
        test_overflow();
        test_scan(123);
        test_scan(7);
        test_scan(0);
        for (int i = 0; i < 3; i++) test_scan(int'($urandom_range(0, 1023)));
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sevenseg_score_scanner.md
Name: sevenseg_score_scanner

Overview:
- Parametrised successor to the fixed 4-digit score display path.
- Converts a binary score to BCD sequentially using double-dabble, one bit per clock.
- Latches the converted digits and time-multiplexes them onto an N-digit common-anode seven-segment display with a configurable scan rate.
- Sits between the game-logic score output and the board's an/seg pins; replaces combinational divide/modulo digit extraction.

Parameters:
- NUM_DIGITS, 4, number of display digits/anodes (1..8).
- BIN_W, 10, width of the binary input value.
- SCAN_DIV, 250000, clk cycles each digit is held during scanning (>=2).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- value  in  BIN_W  binary score to display.
- load  in  1  single-cycle request to convert and display value.
- busy  out  1  conversion in progress.
- ovf  out  1  last committed value exceeded 10^NUM_DIGITS-1.
- bcd  out  4*NUM_DIGITS  committed BCD digits; digit 0 is least significant, in bits [3:0].
- an  out  NUM_DIGITS  anode enables, active low; an[0] selects digit 0.
- seg  out  7  segments {g,f,e,d,c,b,a}, active low.

Behaviour:
- Reset values, applied asynchronously: busy=0, ovf=0, bcd=0, an=all ones, seg=7'b1111111, scan index=0, divider=0, pending=0.
- Conversion FSM states:
  - IDLE: load=1 captures value into the shift register, clears the BCD accumulator and sets bit counter=BIN_W; next state SHIFT.
  - SHIFT: each cycle, add 3 to every accumulator nibble >=5, then shift {acc,shreg} left by 1 and decrement the counter. Leave SHIFT after BIN_W cycles; next state COMMIT.
  - COMMIT: if captured value > 10^NUM_DIGITS-1, bcd<=all nibbles 9 and ovf<=1; else bcd<=acc and ovf<=0. Next state IDLE, or SHIFT if pending.
- busy=1 in SHIFT and COMMIT. busy rises the cycle after load is accepted, stays high exactly BIN_W+1 cycles, and falls on the same edge bcd/ovf update.
- Overflow compare uses the value captured at load, not the live input.
- The accumulator is 4*NUM_DIGITS bits; bits shifted out of the top during overflow are discarded.
- Load while busy: value is stored in a pending register, overwriting any earlier pending value, and the pending flag is set.
  - At COMMIT, a set pending flag starts a new conversion immediately with no IDLE cycle; busy stays high.
- Load in COMMIT is treated as pending.
- Scanning:
  - Divider counts 0..SCAN_DIV-1. At terminal count it wraps to 0 and the scan index advances; index NUM_DIGITS-1 wraps to 0.
  - an and seg are registered and follow the scan index with 1 clk latency.
  - Exactly one an bit is low at a time, except under blanking.
  - seg shows the committed digit for the current index.
- Segment codes (active low, gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Nibbles above 9 are unreachable; they must decode to blank.
- Scanning runs continuously and independently of conversion; bcd changes only at COMMIT, so the display never shows partial results.
- Reset asserted mid-conversion aborts the conversion, drops the pending request and restores all reset values.

Optional Feature:
- Macro: SEVENSEG_LZ_BLANK_EN.
- Defined: leading-zero blanking. Every digit above the most significant nonzero committed digit is blanked: seg=1111111 and its an bit held high. Digit 0 is always shown, so value 0 displays "0". ovf=1 shows all 9s, unblanked.
- Undefined: all NUM_DIGITS digits are shown, including leading zeros.

Test Plan:
- Assert rst with no clock edge -> immediately busy=0, ovf=0, bcd=0, an=4'b1111, seg=7'b1111111.
- Defaults, SCAN_DIV=4: pulse load with value=123 -> busy high 11 cycles, then bcd=16'h0123, ovf=0. Over 16 cycles an steps 1110, 1101, 1011, 0111 with seg 0110000, 0100100, 1111001, 1000000.
- NUM_DIGITS=3, BIN_W=10: load value=1023 -> bcd=12'h999, ovf=1. Then load 999 -> bcd=12'h999, ovf=0.
- Load 5, then load 42 and load 77 while busy -> first commit bcd=0005. busy stays high, second commit bcd=0077. Value 42 is never committed.
- Load 500, assert rst 4 cycles into SHIFT -> all outputs at reset values; no commit occurs after rst releases.
- SEVENSEG_LZ_BLANK_EN defined, load 7 -> only an[0] ever goes low, seg=1111000. Load 0 -> digit 0 shows 1000000.
